// File: rtl/cdf_divider_seq.sv
// -----------------------------------------------------------------------------
// cdf_divider_seq
//
// Iterative divider for the histogram-equalisation remap path. For every
// accepted bin it produces
//
//   g = floor((cdf_in - cdf_min) * (2^PIX_W - 1) / (cdf_total - cdf_min))
//
// using restoring radix-2 division, one quotient bit per clock, MSB first.
// Degenerate inputs (empty range, bin at or below cdf_min, bin at or above
// cdf_total) bypass the divider and finish in a single cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous reset, active low (0 = reset)
//   cdf_min    in   CDF_W  first non-zero CDF value, sampled on accept
//   cdf_total  in   CDF_W  total pixel count, sampled on accept
//   in_valid   in   1      cdf_in valid
//   in_ready   out  1      block can accept cdf_in (IDLE only)
//   cdf_in     in   CDF_W  cumulative count for the current bin
//   out_valid  out  1      g_out valid (DONE)
//   out_ready  in   1      downstream accepts g_out
//   g_out      out  PIX_W  equalised grey level, held after handshake
//   busy       out  1      high in CALC or DONE
// -----------------------------------------------------------------------------
module cdf_divider_seq #(
  parameter int CDF_W = 16,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CDF_W-1:0] cdf_min,
  input  logic [CDF_W-1:0] cdf_total,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CDF_W-1:0] cdf_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] g_out,
  output logic             busy
);

  localparam int NUM_W = CDF_W + PIX_W;
  localparam int CNT_W = $clog2(NUM_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PIX_W-1:0] G_MAX = '1;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // (d * (2^PIX_W - 1)) computed as (d << PIX_W) - d; no multiplier needed.
  function automatic logic [NUM_W-1:0] scale_num(input logic [CDF_W-1:0] d);
    logic [NUM_W-1:0] wide;
    wide = {{PIX_W{1'b0}}, d};
    return (wide << PIX_W) - wide;
  endfunction

  // One restoring-division step. The numerator occupies quo: its MSB is
  // shifted into the remainder while the new quotient bit enters at the LSB,
  // so after NUM_W steps quo holds the full quotient.
  // Returns {remainder_next, quo_next}.
  function automatic logic [CDF_W+NUM_W:0] div_step(
    input logic [CDF_W:0]   rem,
    input logic [NUM_W-1:0] quo,
    input logic [CDF_W-1:0] den
  );
    logic [CDF_W:0] sh;
    sh = {rem[CDF_W-1:0], quo[NUM_W-1]};
    if (sh >= {1'b0, den}) begin
      return {sh - {1'b0, den}, quo[NUM_W-2:0], 1'b1};
    end
    return {sh, quo[NUM_W-2:0], 1'b0};
  endfunction

  // The quotient cannot exceed 2^PIX_W - 1 for in-range inputs, but clamp
  // rather than wrap if an upper bit ever appears.
  function automatic logic [PIX_W-1:0] sat_quo(input logic [NUM_W-1:0] q);
    if (|q[NUM_W-1:PIX_W]) begin
      return G_MAX;
    end
    return q[PIX_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [CDF_W-1:0] den_q;
  logic [CDF_W:0]   rem_q;
  logic [NUM_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;   // division steps still to perform
  logic [PIX_W-1:0] g_q;

  // ---------------------------------------------------------------------------
  // Accept-time decode
  // ---------------------------------------------------------------------------
  logic             accept;
  logic [CDF_W-1:0] den_in;
  logic [NUM_W-1:0] num_in;
  logic             sp_zero;
  logic             sp_sat;

  assign accept = (state == S_IDLE) && in_valid;
  assign den_in = cdf_total - cdf_min;
  // Wraps when cdf_in < cdf_min, but that case never reaches the divider.
  assign num_in = scale_num(cdf_in - cdf_min);

  // Empty or inverted range and bins at/below cdf_min all map to black;
  // only then do bins at/above cdf_total saturate to white.
  assign sp_zero = (den_in == '0) || (cdf_min > cdf_total) || (cdf_in <= cdf_min);
  assign sp_sat  = !sp_zero && (cdf_in >= cdf_total);

  // ---------------------------------------------------------------------------
  // Shared division step. The first step runs on the accept edge straight
  // from the port values, the remaining NUM_W-1 steps run in CALC from the
  // captured registers.
  // ---------------------------------------------------------------------------
  logic [CDF_W:0]   step_rem;
  logic [NUM_W-1:0] step_quo;
  logic [CDF_W-1:0] step_den;
  logic [CDF_W:0]   rem_nx;
  logic [NUM_W-1:0] quo_nx;

  always_comb begin
    step_rem = '0;
    step_quo = num_in;
    step_den = den_in;
    if (state == S_CALC) begin
      step_rem = rem_q;
      step_quo = quo_q;
      step_den = den_q;
    end
    {rem_nx, quo_nx} = div_step(step_rem, step_quo, step_den);
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      den_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      g_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (sp_zero) begin
              g_q   <= '0;
              state <= S_DONE;
            end else if (sp_sat) begin
              g_q   <= G_MAX;
              state <= S_DONE;
            end else begin
              den_q <= den_in;
              rem_q <= rem_nx;
              quo_q <= quo_nx;
              cnt_q <= CNT_W'(NUM_W - 1);
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last step: the counter reaches zero as the result is registered.
          if (cnt_q == CNT_W'(1)) begin
            g_q   <= sat_quo(quo_nx);
            state <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state so they clear as soon as reset
  // asserts)
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC) || (state == S_DONE);
  assign g_out     = g_q;

endmodule

// File: tb/tb_cdf_divider_seq.sv
module tb_cdf_divider_seq;

  logic clk;
  logic reset;

  // Instance 0: CDF_W=16, PIX_W=8
  logic [15:0] mn0, tot0, ci0;
  logic        iv0, ir0, ov0, or0, bz0;
  logic [7:0]  g0;
  // Instance 1: CDF_W=12, PIX_W=6
  logic [11:0] mn1, tot1, ci1;
  logic        iv1, ir1, ov1, or1, bz1;
  logic [5:0]  g1;
  // Instance 2: CDF_W=20, PIX_W=10
  logic [19:0] mn2, tot2, ci2;
  logic        iv2, ir2, ov2, or2, bz2;
  logic [9:0]  g2;

  cdf_divider_seq #(.CDF_W(16), .PIX_W(8)) dut0 (
    .clk(clk), .reset(reset), .cdf_min(mn0), .cdf_total(tot0),
    .in_valid(iv0), .in_ready(ir0), .cdf_in(ci0),
    .out_valid(ov0), .out_ready(or0), .g_out(g0), .busy(bz0)
  );
  cdf_divider_seq #(.CDF_W(12), .PIX_W(6)) dut1 (
    .clk(clk), .reset(reset), .cdf_min(mn1), .cdf_total(tot1),
    .in_valid(iv1), .in_ready(ir1), .cdf_in(ci1),
    .out_valid(ov1), .out_ready(or1), .g_out(g1), .busy(bz1)
  );
  cdf_divider_seq #(.CDF_W(20), .PIX_W(10)) dut2 (
    .clk(clk), .reset(reset), .cdf_min(mn2), .cdf_total(tot2),
    .in_valid(iv2), .in_ready(ir2), .cdf_in(ci2),
    .out_valid(ov2), .out_ready(or2), .g_out(g2), .busy(bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int sb0[$];
  int sb1[$];
  int sb2[$];

  typedef struct {
    int w;
    int mn;
    int tot;
    int ci;
    int g;
    int lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: plain floor division with the special-case priority.
  function automatic int ref_g(input int pw, input longint mn, input longint tot,
                               input longint ci);
    longint sc;
    sc = (longint'(1) << pw) - 1;
    if (tot <= mn) return 0;
    if (ci <= mn) return 0;
    if (ci >= tot) return int'(sc);
    return int'(((ci - mn) * sc) / (tot - mn));
  endfunction

  function automatic int ref_lat(input int numw, input int mn, input int tot, input int ci);
    if ((tot <= mn) || (ci <= mn) || (ci >= tot)) return 1;
    return numw;
  endfunction

  task automatic set_in(input int w, input int mn, input int tot, input int ci, input logic iv);
    case (w)
      0: begin mn0 = 16'(mn); tot0 = 16'(tot); ci0 = 16'(ci); iv0 = iv; end
      1: begin mn1 = 12'(mn); tot1 = 12'(tot); ci1 = 12'(ci); iv1 = iv; end
      default: begin mn2 = 20'(mn); tot2 = 20'(tot); ci2 = 20'(ci); iv2 = iv; end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  function automatic int get_ir(input int w);
    case (w)
      0: return int'(ir0);
      1: return int'(ir1);
      default: return int'(ir2);
    endcase
  endfunction

  function automatic int get_ov(input int w);
    case (w)
      0: return int'(ov0);
      1: return int'(ov1);
      default: return int'(ov2);
    endcase
  endfunction

  function automatic int get_bz(input int w);
    case (w)
      0: return int'(bz0);
      1: return int'(bz1);
      default: return int'(bz2);
    endcase
  endfunction

  function automatic int get_g(input int w);
    case (w)
      0: return int'(g0);
      1: return int'(g1);
      default: return int'(g2);
    endcase
  endfunction

  function automatic int get_x(input int w);
    case (w)
      0: return int'($isunknown({ir0, ov0, bz0, g0}));
      1: return int'($isunknown({ir1, ov1, bz1, g1}));
      default: return int'($isunknown({ir2, ov2, bz2, g2}));
    endcase
  endfunction

  task automatic sb_push(input int w, input int v);
    case (w)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int w, output int v);
    v = -1;
    case (w)
      0: if (sb0.size() > 0) v = sb0.pop_front();
      1: if (sb1.size() > 0) v = sb1.pop_front();
      default: if (sb2.size() > 0) v = sb2.pop_front();
    endcase
  endtask

  // One complete transaction: accept, wait for the result (bounded), hold
  // out_ready low for 'stall' cycles, then hand-shake. new_mn >= 0 changes
  // cdf_min after the accept edge; the result must not be affected.
  task automatic run_txn(input int w, input int mn, input int tot, input int ci,
                         input int exp_g, input int exp_lat, input int stall,
                         input int new_mn);
    int lat;
    int g_first;
    int exp_v;
    @(negedge clk);
    chk($sformatf("w%0d_in_ready_idle", w), get_ir(w), 1);
    set_in(w, mn, tot, ci, 1'b1);
    set_or(w, 1'b0);
    sb_push(w, exp_g);
    @(posedge clk);
    @(negedge clk);
    set_in(w, (new_mn >= 0) ? new_mn : mn, tot, ci, 1'b0);
    if (exp_lat > 1) begin
      chk($sformatf("w%0d_busy_calc", w), get_bz(w), 1);
      chk($sformatf("w%0d_in_ready_calc", w), get_ir(w), 0);
    end
    lat = 1;
    while ((get_ov(w) == 0) && (lat < 100)) begin
      @(negedge clk);
      lat++;
    end
    sb_pop(w, exp_v);
    if (get_ov(w) == 0) begin
      chk($sformatf("w%0d_out_valid_timeout", w), 0, 1);
      return;
    end
    if (exp_lat > 0) chk($sformatf("w%0d_latency mn=%0d tot=%0d in=%0d", w, mn, tot, ci), lat, exp_lat);
    g_first = get_g(w);
    chk($sformatf("w%0d_g mn=%0d tot=%0d in=%0d", w, mn, tot, ci), g_first, exp_v);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("w%0d_stall_g_stable", w), get_g(w), exp_v);
      chk($sformatf("w%0d_stall_out_valid", w), get_ov(w), 1);
      chk($sformatf("w%0d_stall_in_ready", w), get_ir(w), 0);
    end
    set_or(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_or(w, 1'b0);
    chk($sformatf("w%0d_out_valid_drop", w), get_ov(w), 0);
    chk($sformatf("w%0d_g_hold", w), get_g(w), exp_v);
  endtask

  task automatic rand_run(input int w, input int n);
    int cw, pw, numw, mx, a, b, mn, tot, ci, mode;
    cw = (w == 0) ? 16 : ((w == 1) ? 12 : 20);
    pw = (w == 0) ? 8 : ((w == 1) ? 6 : 10);
    numw = cw + pw;
    mx = (1 << cw) - 1;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, mx));
      b = int'($urandom_range(0, mx));
      mode = int'($urandom_range(0, 15));
      if (mode == 0) begin
        mn = (a > b) ? a : b;
        tot = (a > b) ? b : a;
      end else if (mode == 1) begin
        mn = a;
        tot = a;
      end else begin
        mn = (a < b) ? a : b;
        tot = (a < b) ? b : a;
      end
      case ($urandom_range(0, 7))
        0: ci = mn;
        1: ci = tot;
        2: ci = int'($urandom_range(0, mx));
        default: ci = (tot > mn) ? int'($urandom_range(mn, tot)) : a;
      endcase
      run_txn(w, mn, tot, ci, ref_g(pw, mn, tot, ci), ref_lat(numw, mn, tot, ci),
              int'($urandom_range(0, 2)), int'($urandom_range(0, mx)));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 1'b0);
    set_in(1, 0, 0, 0, 1'b0);
    set_in(2, 0, 0, 0, 1'b0);
    or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(ir0), 1);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_g", int'(g0), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(ir0), 1);
    chk("rel_out_valid", int'(ov0), 0);

    // Directed vectors
    tbl.push_back('{0, 10, 1034, 522, 127, 24});
    tbl.push_back('{0, 10, 1034, 1034, 255, 1});
    tbl.push_back('{0, 10, 1034, 5, 0, 1});
    tbl.push_back('{0, 10, 1034, 11, 0, 24});
    tbl.push_back('{0, 10, 10, 10, 0, 1});
    tbl.push_back('{0, 10, 1034, 10, 0, 1});
    tbl.push_back('{0, 20, 10, 15, 0, 1});
    tbl.push_back('{0, 10, 1034, 778, 191, 24});
    tbl.push_back('{0, 10, 1034, 1033, 254, 24});
    tbl.push_back('{0, 0, 65535, 65534, 254, 24});
    tbl.push_back('{0, 0, 65535, 1, 0, 24});
    tbl.push_back('{0, 0, 2, 1, 127, 24});
    tbl.push_back('{1, 0, 4095, 2048, 31, 18});
    tbl.push_back('{1, 100, 50, 4095, 0, 1});
    tbl.push_back('{2, 0, 1048575, 524288, 511, 30});
    tbl.push_back('{2, 5, 1000, 2000, 1023, 1});
    foreach (tbl[i]) begin
      run_txn(tbl[i].w, tbl[i].mn, tbl[i].tot, tbl[i].ci, tbl[i].g, tbl[i].lat, 0, -1);
      chk($sformatf("w%0d_no_x_vec%0d", tbl[i].w, i), get_x(tbl[i].w), 0);
    end

    // Output stall of 10 cycles with cdf_min changed mid-CALC
    run_txn(0, 10, 1034, 522, 127, 24, 10, 500);

    // Asynchronous reset pulse between edges while holding a result in DONE
    @(negedge clk);
    set_in(0, 10, 1034, 522, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 10, 1034, 522, 1'b0);
    repeat (30) @(negedge clk);
    chk("done_hold_out_valid", int'(ov0), 1);
    chk("done_hold_g", int'(g0), 127);
    #2;
    reset = 1'b0;
    #1;
    chk("async_in_ready", int'(ir0), 1);
    chk("async_out_valid", int'(ov0), 0);
    chk("async_busy", int'(bz0), 0);
    chk("async_g", int'(g0), 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset at iteration 12 of CALC discards that result
    @(negedge clk);
    set_in(0, 10, 1034, 522, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 10, 1034, 522, 1'b0);
    repeat (11) @(negedge clk);
    chk("midcalc_busy", int'(bz0), 1);
    reset = 1'b0;
    #1;
    chk("midcalc_rst_busy", int'(bz0), 0);
    chk("midcalc_rst_in_ready", int'(ir0), 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ov0) seen = 1;
    end
    chk("midcalc_no_stale_result", seen, 0);
    run_txn(0, 10, 1034, 778, 191, 24, 0, -1);

    // Random traffic on all three parameter sets in parallel
    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
